// File: rtl/ex_if.sv
// ex_if: ID/EX-to-MEM bundle for the execute stage.
// master: driven by the ID/EX side (operation, operands, destination, flush);
//         observes the results, stall request and HI/LO.
// slave : the execute stage itself.
interface ex_if;
  logic [4:0]  aluOp_i;
  logic [31:0] operand1_i;
  logic [31:0] operand2_i;
  logic [4:0]  writeAddr_i;
  logic        writeEnable_i;
  logic        flush_i;
  logic [31:0] result_o;
  logic [4:0]  writeAddr_o;
  logic        writeEnable_o;
  logic        stallReq_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output aluOp_i, operand1_i, operand2_i, writeAddr_i, writeEnable_i, flush_i,
    input  result_o, writeAddr_o, writeEnable_o, stallReq_o, hi_o, lo_o
  );

  modport slave (
    input  aluOp_i, operand1_i, operand2_i, writeAddr_i, writeEnable_i, flush_i,
    output result_o, writeAddr_o, writeEnable_o, stallReq_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex.sv
// ex: MIPS32 execute stage.
// Combinational integer ALU feeding MEM, plus the HI/LO register pair written
// by MULT/MULTU (single cycle), MTHI/MTLO, and an iterative restoring divider
// for DIV/DIVU that stalls the pipeline until the quotient is ready.
// Ports:
//   clk  - pipeline clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - ex_if.slave: operation/operands/destination/flush in;
//          result/destination/write enable/stall request/HI/LO out
module ex #(
  parameter int unsigned DIV_STEPS = 32
) (
  input logic clk,
  input logic rst,
  ex_if.slave bus
);

  typedef enum logic [4:0] {
    OP_NOP   = 5'd0,
    OP_ADD   = 5'd1,
    OP_SUB   = 5'd2,
    OP_AND   = 5'd3,
    OP_OR    = 5'd4,
    OP_XOR   = 5'd5,
    OP_NOR   = 5'd6,
    OP_SLT   = 5'd7,
    OP_SLTU  = 5'd8,
    OP_SLL   = 5'd9,
    OP_SRL   = 5'd10,
    OP_SRA   = 5'd11,
    OP_MFHI  = 5'd12,
    OP_MFLO  = 5'd13,
    OP_DIV   = 5'd14,
    OP_DIVU  = 5'd15,
    OP_MULT  = 5'd16,
    OP_MULTU = 5'd17,
    OP_MTHI  = 5'd18,
    OP_MTLO  = 5'd19
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } div_state_e;

  localparam int unsigned CW = $clog2(DIV_STEPS + 1);

  logic [4:0]  op;
  logic [31:0] op1;
  logic [31:0] op2;

  assign op  = bus.aluOp_i;
  assign op1 = bus.operand1_i;
  assign op2 = bus.operand2_i;

  logic [31:0] hi;
  logic [31:0] lo;

  // ALU

  logic [31:0] alu_result;
  logic        alu_we;

  always_comb begin
    alu_result = '0;
    alu_we     = 1'b0;
    case (op)
      OP_ADD:  begin alu_result = op1 + op2;                               alu_we = 1'b1; end
      OP_SUB:  begin alu_result = op1 - op2;                               alu_we = 1'b1; end
      OP_AND:  begin alu_result = op1 & op2;                               alu_we = 1'b1; end
      OP_OR:   begin alu_result = op1 | op2;                               alu_we = 1'b1; end
      OP_XOR:  begin alu_result = op1 ^ op2;                               alu_we = 1'b1; end
      OP_NOR:  begin alu_result = ~(op1 | op2);                            alu_we = 1'b1; end
      OP_SLT:  begin alu_result = {31'b0, $signed(op1) < $signed(op2)};    alu_we = 1'b1; end
      OP_SLTU: begin alu_result = {31'b0, op1 < op2};                      alu_we = 1'b1; end
      OP_SLL:  begin alu_result = op2 << op1[4:0];                         alu_we = 1'b1; end
      OP_SRL:  begin alu_result = op2 >> op1[4:0];                         alu_we = 1'b1; end
      OP_SRA:  begin alu_result = $unsigned($signed(op2) >>> op1[4:0]);    alu_we = 1'b1; end
      OP_MFHI: begin alu_result = hi;                                      alu_we = 1'b1; end
      OP_MFLO: begin alu_result = lo;                                      alu_we = 1'b1; end
      default: begin alu_result = '0;                                      alu_we = 1'b0; end
    endcase
  end

  assign bus.result_o      = rst ? '0   : alu_result;
  assign bus.writeAddr_o   = rst ? '0   : bus.writeAddr_i;
  assign bus.writeEnable_o = rst ? 1'b0 : (bus.writeEnable_i & alu_we);
  assign bus.hi_o          = hi;
  assign bus.lo_o          = lo;

  // Multiplier (full 64-bit product, single cycle)

  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign prod_s = $unsigned($signed({{32{op1[31]}}, op1}) * $signed({{32{op2[31]}}, op2}));
  assign prod_u = {32'b0, op1} * {32'b0, op2};

  // Divider

  div_state_e  state;
  div_state_e  state_nxt;
  logic [CW-1:0] step;
  logic [31:0] rem;
  logic [31:0] quot;
  logic [31:0] divisor;
  logic        q_neg;
  logic        r_neg;
  logic        is_signed_div;
  logic        div_start;
  logic        stall;

  assign is_signed_div = (op == OP_DIV);
  assign div_start     = ((op == OP_DIV) || (op == OP_DIVU)) && (op2 != '0);

  // quot starts as the dividend and shifts left one bit per step, while the
  // quotient bits fill in from the bottom.
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        step_bit;
  logic [31:0] step_rem;

  assign shifted  = {rem, quot[31]};
  assign diff     = shifted - {1'b0, divisor};
  assign step_bit = ~diff[32];
  assign step_rem = diff[32] ? shifted[31:0] : diff[31:0];

  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  assign quot_fix = q_neg ? -quot : quot;
  assign rem_fix  = r_neg ? -rem  : rem;

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      S_IDLE: begin
        if (div_start) begin
          stall = 1'b1;
          if (!bus.flush_i) state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        if (bus.flush_i)                      state_nxt = S_IDLE;
        else if (step == CW'(DIV_STEPS - 1)) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.stallReq_o = rst ? 1'b0 : stall;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi      <= '0;
      lo      <= '0;
      step    <= '0;
      rem     <= '0;
      quot    <= '0;
      divisor <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (div_start && !bus.flush_i) begin
            quot    <= (is_signed_div && op1[31]) ? -op1 : op1;
            divisor <= (is_signed_div && op2[31]) ? -op2 : op2;
            q_neg   <= is_signed_div && (op1[31] ^ op2[31]);
            r_neg   <= is_signed_div && op1[31];
            rem     <= '0;
            step    <= '0;
          end
        end
        S_BUSY: begin
          rem  <= step_rem;
          quot <= {quot[30:0], step_bit};
          step <= step + CW'(1);
        end
        default: ;
      endcase

      // Divider completion wins; other HI/LO writers only act while not stalled.
      if (state == S_DONE && !bus.flush_i) begin
        hi <= rem_fix;
        lo <= quot_fix;
      end else if (!stall) begin
        case (op)
          OP_MULT:  {hi, lo} <= prod_s;
          OP_MULTU: {hi, lo} <= prod_u;
          OP_MTHI:  hi <= op1;
          OP_MTLO:  lo <= op1;
          default: ;
        endcase
      end
    end
  end

endmodule
